// File: rtl/imem_program_loader.sv
// Encodes decoded RV32I instruction fields into 32-bit words and writes them
// to consecutive instruction-memory word addresses, one session per Start.
module imem_program_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start,
   input  logic                  InValid,
   output logic                  InReady,
   input  logic [6:0]            Op,
   input  logic [2:0]            Funct3,
   input  logic [6:0]            Funct7,
   input  logic [4:0]            Rd,
   input  logic [4:0]            Rs1,
   input  logic [4:0]            Rs2,
   input  logic [31:0]           Imm,
   input  logic                  Last,
   output logic                  MemWE,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [31:0]           MemWD,
   output logic [ADDR_WIDTH:0]   Count,
   output logic                  Done,
   output logic [1:0]            ErrCode
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_OP    = 2'b01;
   localparam logic [1:0] ERR_IMM   = 2'b10;
   localparam logic [1:0] ERR_OVFL  = 2'b11;

   localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] COUNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                r_state;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [31:0]           r_mem_wd;
   logic [ADDR_WIDTH:0]   r_count;
   logic [1:0]            r_err;

   logic                  w_handshake;
   logic                  w_op_known;
   logic                  w_imm_ok;
   logic                  w_imm12_fits;
   logic                  w_imm13_fits;
   logic [31:0]           w_word;
   logic [ADDR_WIDTH:0]   w_count_inc;

   // Fits in the 12-bit (I/S) or 13-bit even (B) signed immediate field
   assign w_imm12_fits = (Imm[31:11] == {21{Imm[11]}});
   assign w_imm13_fits = (Imm[31:12] == {20{Imm[12]}}) && !Imm[0];

   always_comb begin
      w_word     = 32'h0;
      w_op_known = 1'b1;
      w_imm_ok   = 1'b1;
      case (Op)
         OP_LOAD, OP_IALU: begin
            w_word   = {Imm[11:0], Rs1, Funct3, Rd, Op};
            w_imm_ok = w_imm12_fits;
         end
         OP_R: begin
            w_word = {Funct7, Rs2, Rs1, Funct3, Rd, Op};
         end
         OP_STORE: begin
            w_word   = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Op};
            w_imm_ok = w_imm12_fits;
         end
         OP_BRANCH: begin
            w_word   = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Op};
            w_imm_ok = w_imm13_fits;
         end
         default: begin
            w_op_known = 1'b0;
         end
      endcase
   end

   assign InReady     = (r_state == S_LOAD) && !Start;
   assign w_handshake = InValid && InReady;
   assign w_count_inc = r_count + COUNT_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mem_we   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_wd   <= 32'h0;
         r_count    <= '0;
         r_err      <= ERR_NONE;
      end else begin
         r_mem_we <= 1'b0;
         if (Start) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_err   <= ERR_NONE;
         end else if (w_handshake) begin
            if (!w_op_known) begin
               r_state <= S_ERROR;
               r_err   <= ERR_OP;
            end else if (!w_imm_ok) begin
               r_state <= S_ERROR;
               r_err   <= ERR_IMM;
            end else begin
               r_mem_we   <= 1'b1;
               r_mem_addr <= r_count[ADDR_WIDTH-1:0];
               r_mem_wd   <= w_word;
               r_count    <= w_count_inc;
               if (Last) begin
                  r_state <= S_DONE;
               end else if (w_count_inc == COUNT_FULL) begin
                  r_state <= S_ERROR;
                  r_err   <= ERR_OVFL;
               end
            end
         end
      end
   end

   // A reset arriving while a write is pending masks that pulse as well
   assign MemWE   = r_mem_we && !rst;
   assign MemAddr = r_mem_addr;
   assign MemWD   = r_mem_wd;
   assign Count   = r_count;
   assign Done    = (r_state == S_DONE);
   assign ErrCode = r_err;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench: a default-size loader for the encoding/error sessions and a
// 4-word loader for address-space overflow, sharing the field inputs.
module tb_imem_program_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic        in_valid = 1'b0;
   logic [6:0]  op = '0;
   logic [2:0]  f3 = '0;
   logic [6:0]  f7 = '0;
   logic [4:0]  rd = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;
   logic [31:0] imm = '0;
   logic        last = 1'b0;

   logic        ready_a, we_a, done_a;
   logic [7:0]  addr_a;
   logic [31:0] wd_a;
   logic [8:0]  count_a;
   logic [1:0]  err_a;

   logic        ready_b, we_b, done_b;
   logic [1:0]  addr_b;
   logic [31:0] wd_b;
   logic [2:0]  count_b;
   logic [1:0]  err_b;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int exp_addr_a = 0;
   int exp_addr_b = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] wd;
      int          cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;

   imem_program_loader #(.ADDR_WIDTH(8)) u_dut_a (
      .clk(clk), .rst(rst), .Start(start_a), .InValid(in_valid), .InReady(ready_a),
      .Op(op), .Funct3(f3), .Funct7(f7), .Rd(rd), .Rs1(rs1), .Rs2(rs2), .Imm(imm),
      .Last(last), .MemWE(we_a), .MemAddr(addr_a), .MemWD(wd_a), .Count(count_a),
      .Done(done_a), .ErrCode(err_a)
   );

   imem_program_loader #(.ADDR_WIDTH(2)) u_dut_b (
      .clk(clk), .rst(rst), .Start(start_b), .InValid(in_valid), .InReady(ready_b),
      .Op(op), .Funct3(f3), .Funct7(f7), .Rd(rd), .Rs1(rs1), .Rs2(rs2), .Imm(imm),
      .Last(last), .MemWE(we_b), .MemAddr(addr_b), .MemWD(wd_b), .Count(count_b),
      .Done(done_b), .ErrCode(err_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Write monitor: every MemWE pulse must match the oldest expected write
   always @(negedge clk) begin
      if (we_a === 1'b1) begin
         if (q_a.size() == 0) begin
            check_eq("a_unexpected_we", 1, 0);
         end else begin
            e_a = q_a.pop_front();
            check_eq("a_addr", addr_a, e_a.addr);
            check_eq("a_wd", wd_a, e_a.wd);
            check_eq("a_write_cycle", cyc, e_a.cyc);
            $display("WR a addr=%0d wd=%08h", addr_a, wd_a);
         end
      end
      if (we_b === 1'b1) begin
         if (q_b.size() == 0) begin
            check_eq("b_unexpected_we", 1, 0);
         end else begin
            e_b = q_b.pop_front();
            check_eq("b_addr", addr_b, e_b.addr);
            check_eq("b_wd", wd_b, e_b.wd);
            check_eq("b_write_cycle", cyc, e_b.cyc);
            $display("WR b addr=%0d wd=%08h", addr_b, wd_b);
         end
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input bit t_b);
      if (t_b) start_b = 1'b1;
      else     start_a = 1'b1;
      @(negedge clk);
      check_eq("ready_low_during_start", t_b ? ready_b : ready_a, 0);
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      if (t_b) exp_addr_b = 0;
      else     exp_addr_a = 0;
   endtask

   // Present one instruction and hold it until accepted; in_valid stays high on return
   task automatic send(input logic [6:0] t_op, input logic [2:0] t_f3, input logic [6:0] t_f7,
                       input logic [4:0] t_rd, input logic [4:0] t_rs1, input logic [4:0] t_rs2,
                       input logic [31:0] t_imm, input logic t_last,
                       input logic t_wr, input logic [31:0] t_word, input bit t_b);
      bit   got;
      exp_t e;
      op = t_op; f3 = t_f3; f7 = t_f7; rd = t_rd; rs1 = t_rs1; rs2 = t_rs2;
      imm = t_imm; last = t_last; in_valid = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if ((t_b ? ready_b : ready_a) === 1'b1) got = 1'b1;
      end
      if (!got) begin
         check_eq("handshake_timeout", 0, 1);
         in_valid = 1'b0;
      end else begin
         if (t_wr) begin
            e.wd  = t_word;
            e.cyc = cyc + 1;
            if (t_b) begin
               e.addr = 8'(exp_addr_b);
               exp_addr_b++;
               q_b.push_back(e);
            end else begin
               e.addr = 8'(exp_addr_a);
               exp_addr_a++;
               q_a.push_back(e);
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_restart;
      idle(1);
      do_start(0);
      @(negedge clk);
      check_eq("restart_ready", ready_a, 1);
      check_eq("restart_count", count_a, 0);
      check_eq("restart_err", err_a, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", ready_a, 0);
      check_eq("rst_we", we_a, 0);
      check_eq("rst_addr", addr_a, 0);
      check_eq("rst_wd", wd_a, 0);
      check_eq("rst_count", count_a, 0);
      check_eq("rst_done", done_a, 0);
      check_eq("rst_err", err_a, 0);
      check_eq("rst_b_ready", ready_b, 0);
      @(posedge clk);
      #1;

      // Four-class program with one idle cycle between words
      do_start(0);
      send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093, 0);
      idle(1);
      send(7'b0110011, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3, 0);
      idle(1);
      send(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 1'b1, 32'h0020A423, 0);
      idle(1);
      send(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b1, 1'b1, 32'hFE208CE3, 0);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("prog_done", done_a, 1);
      check_eq("prog_count", count_a, 4);
      check_eq("prog_ready_after_last", ready_a, 0);
      @(posedge clk);
      #1;
      idle(2);
      check_eq("done_holds", done_a, 1);

      // Back-to-back loads: one write per cycle
      do_start(0);
      repeat (3) send(7'b0000011, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b0, 1'b1, 32'hFFC12283, 0);
      idle(1);
      check_eq("b2b_count", count_a, 3);

      // Unsupported opcode
      do_start(0);
      send(7'b0110111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0, 32'h0, 0);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("badop_err", err_a, 1);
      check_eq("badop_ready", ready_a, 0);
      check_eq("badop_count", count_a, 0);
      @(posedge clk);
      #1;
      check_restart();

      // Store at upper imm bound accepted, I-ALU 2048 rejected
      send(7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd2047, 1'b0, 1'b1, 32'h7E20AFA3, 0);
      send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'h0, 0);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("imm2048_err", err_a, 2);
      check_eq("imm2048_count", count_a, 1);
      check_eq("imm2048_ready", ready_a, 0);
      @(posedge clk);
      #1;
      check_restart();

      // Branch offset 6 accepted, odd offset 7 rejected
      send(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd6, 1'b0, 1'b1, 32'h00208363, 0);
      send(7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 1'b0, 32'h0, 0);
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("br_odd_err", err_a, 2);
      check_eq("br_odd_count", count_a, 1);
      check_eq("br_odd_done", done_a, 0);
      @(posedge clk);
      #1;
      check_restart();

      // Start alongside a valid word in LOAD: not accepted, Count cleared
      send(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 1'b1, 32'h00100093, 0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("pre_start_count", count_a, 1);
      start_a = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      check_eq("start_valid_ready", ready_a, 0);
      @(posedge clk);
      #1;
      start_a = 1'b0;
      in_valid = 1'b0;
      exp_addr_a = 0;
      @(negedge clk);
      check_eq("start_valid_count", count_a, 0);
      @(posedge clk);
      #1;

      // Reset the cycle after a handshake suppresses the pending write
      send(7'b0010011, 3'b000, 7'd0, 5'd2, 5'd0, 5'd0, 32'd9, 1'b0, 1'b0, 32'h0, 0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_pending_we", we_a, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst2_we", we_a, 0);
      check_eq("rst2_addr", addr_a, 0);
      check_eq("rst2_wd", wd_a, 0);
      check_eq("rst2_count", count_a, 0);
      check_eq("rst2_ready", ready_a, 0);
      check_eq("rst2_err", err_a, 0);
      @(posedge clk);
      #1;

      // Four-word memory, five words without Last
      do_start(1);
      for (int k = 1; k <= 4; k++) begin
         send(7'b0010011, 3'b000, 7'd0, 5'(k), 5'd0, 5'd0, 32'(k), 1'b0, 1'b1,
              (32'(k) << 20) | (32'(k) << 7) | 32'h13, 1);
      end
      send_fifth: begin
         op = 7'b0010011; rd = 5'd5; imm = 32'd5; in_valid = 1'b1;
      end
      @(negedge clk);
      check_eq("ovfl_err", err_b, 3);
      check_eq("ovfl_count", count_b, 4);
      repeat (3) begin
         @(negedge clk);
         check_eq("ovfl_fifth_ready", ready_b, 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("ovfl_final_count", count_b, 4);
      @(posedge clk);
      #1;

      idle(3);
      check_eq("a_pending_writes", q_a.size(), 0);
      check_eq("b_pending_writes", q_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
